// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS sequencer.
package mc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_ADDR   = 3'd4,
        ST_MEM    = 3'd5,
        ST_WB     = 3'd6,
        ST_BRANCH = 3'd7
    } state_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;

    localparam logic [1:0] ALUOP_FUNCT = 2'b00;
    localparam logic [1:0] ALUOP_ADD   = 2'b01;
    localparam logic [1:0] ALUOP_OR    = 2'b10;
    localparam logic [1:0] ALUOP_SUB   = 2'b11;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

endpackage

// File: rtl/mc_if.sv
// Controller <-> datapath/memory bundle; master is the sequencer side.
interface mc_if #(
    parameter int CNT_W = 32
);
    logic             start_i;
    logic             stop_i;
    logic [5:0]       Op_i;
    logic             Zero_i;
    logic             mem_ack_i;
    logic             PCWrite_o;
    logic             PCSource_o;
    logic             IorD_o;
    logic             Memory_read_o;
    logic             Memory_write_o;
    logic             IRWrite_o;
    logic             ALUSrcA_o;
    logic [1:0]       ALUSrcB_o;
    logic [1:0]       ALUOp_o;
    logic             RegDst_o;
    logic             RegWrite_o;
    logic             MemtoReg_o;
    logic             busy_o;
    logic             illegal_o;
    logic             mem_err_o;
    logic [CNT_W-1:0] retired_o;

    modport master (
        input  start_i, stop_i, Op_i, Zero_i, mem_ack_i,
        output PCWrite_o, PCSource_o, IorD_o, Memory_read_o, Memory_write_o,
               IRWrite_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o, RegDst_o, RegWrite_o,
               MemtoReg_o, busy_o, illegal_o, mem_err_o, retired_o
    );

    modport slave (
        output start_i, stop_i, Op_i, Zero_i, mem_ack_i,
        input  PCWrite_o, PCSource_o, IorD_o, Memory_read_o, Memory_write_o,
               IRWrite_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o, RegDst_o, RegWrite_o,
               MemtoReg_o, busy_o, illegal_o, mem_err_o, retired_o
    );
endinterface

// File: rtl/mc_mem_timer.sv
// Memory wait counter; expired_o flags the last cycle a request may still be acked.
module mc_mem_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: one instruction at a time through fetch/decode/execute/mem/wb.
// state  | meaning
// IDLE   | parked, waiting for start_i
// FETCH  | read instruction at PC, PC+4 on ack
// DECODE | latch opcode, branch target into ALUOut
// EXEC   | R-type / addi / ori ALU operation
// ADDR   | lw/sw effective address
// MEM    | lw/sw data access, held until ack
// WB     | register-file write
// BRANCH | beq compare, conditional PC write
module multicycle_control
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    mc_if.master bus
);

    state_e           state_q, state_d;
    logic [5:0]       op_q, op_d;
    logic             illegal_q, illegal_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;
    logic             boundary;
    logic             tmr_clr;
    logic             tmr_expired;

    // Counter only runs while a request is outstanding; an ack clears it so sw->FETCH starts fresh.
    assign tmr_clr = !(state_q == ST_FETCH || state_q == ST_MEM) || bus.mem_ack_i;

    mc_mem_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (tmr_clr),
        .en_i      (!bus.mem_ack_i),
        .expired_o (tmr_expired)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        mem_err_d = mem_err_q;
        retire    = 1'b0;
        boundary  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (bus.mem_ack_i) begin
                    state_d = ST_DECODE;
                end else if (tmr_expired) begin
                    mem_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_DECODE: begin
                op_d = bus.Op_i;
                case (bus.Op_i)
                    OP_R, OP_ADDI, OP_ORI: state_d = ST_EXEC;
                    OP_LW, OP_SW:          state_d = ST_ADDR;
                    OP_BEQ:                state_d = ST_BRANCH;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                endcase
            end
            ST_EXEC: state_d = ST_WB;
            ST_ADDR: state_d = ST_MEM;
            ST_MEM: begin
                if (bus.mem_ack_i) begin
                    if (op_q == OP_LW) begin
                        state_d = ST_WB;
                    end else begin
                        retire   = 1'b1;
                        boundary = 1'b1;
                    end
                end else if (tmr_expired) begin
                    mem_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_WB, ST_BRANCH: begin
                retire   = 1'b1;
                boundary = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        if (boundary) state_d = bus.stop_i ? ST_IDLE : ST_FETCH;
        if (state_d == ST_FETCH && state_q != ST_FETCH) begin
            illegal_d = 1'b0;
            mem_err_d = 1'b0;
        end
        retired_d = retired_q + {{(CNT_W-1){1'b0}}, retire};
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
            mem_err_q <= mem_err_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        bus.PCWrite_o      = 1'b0;
        bus.PCSource_o     = 1'b0;
        bus.IorD_o         = 1'b0;
        bus.Memory_read_o  = 1'b0;
        bus.Memory_write_o = 1'b0;
        bus.IRWrite_o      = 1'b0;
        bus.ALUSrcA_o      = 1'b0;
        bus.ALUSrcB_o      = SRCB_RT;
        bus.ALUOp_o        = ALUOP_FUNCT;
        bus.RegDst_o       = 1'b0;
        bus.RegWrite_o     = 1'b0;
        bus.MemtoReg_o     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                bus.Memory_read_o = 1'b1;
                bus.ALUSrcB_o     = SRCB_FOUR;
                bus.ALUOp_o       = ALUOP_ADD;
                bus.IRWrite_o     = bus.mem_ack_i;
                bus.PCWrite_o     = bus.mem_ack_i;
            end
            ST_DECODE: begin
                bus.ALUSrcB_o = SRCB_IMM_SH;
                bus.ALUOp_o   = ALUOP_ADD;
            end
            ST_EXEC: begin
                bus.ALUSrcA_o = 1'b1;
                if (op_q == OP_R) begin
                    bus.ALUSrcB_o = SRCB_RT;
                    bus.ALUOp_o   = ALUOP_FUNCT;
                end else if (op_q == OP_ADDI) begin
                    bus.ALUSrcB_o = SRCB_IMM;
                    bus.ALUOp_o   = ALUOP_ADD;
                end else begin
                    bus.ALUSrcB_o = SRCB_IMM;
                    bus.ALUOp_o   = ALUOP_OR;
                end
            end
            ST_ADDR: begin
                bus.ALUSrcA_o = 1'b1;
                bus.ALUSrcB_o = SRCB_IMM;
                bus.ALUOp_o   = ALUOP_ADD;
            end
            ST_MEM: begin
                bus.IorD_o         = 1'b1;
                bus.Memory_read_o  = (op_q == OP_LW);
                bus.Memory_write_o = (op_q == OP_SW);
            end
            ST_WB: begin
                bus.RegWrite_o = 1'b1;
                bus.RegDst_o   = (op_q == OP_R);
                bus.MemtoReg_o = (op_q == OP_LW);
            end
            ST_BRANCH: begin
                bus.ALUSrcA_o  = 1'b1;
                bus.ALUSrcB_o  = SRCB_RT;
                bus.ALUOp_o    = ALUOP_SUB;
                bus.PCSource_o = 1'b1;
                bus.PCWrite_o  = bus.Zero_i;
            end
            default: ;
        endcase
    end

    assign bus.busy_o    = (state_q != ST_IDLE);
    assign bus.illegal_o = illegal_q;
    assign bus.mem_err_o = mem_err_q;
    assign bus.retired_o = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected output sequences built from the ISA timing rules.
module tb_multicycle_control;

    localparam int MEM_TIMEOUT = 15;
    localparam int CNT_W       = 32;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_ORI  = 6'b001101;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_J    = 6'b000010;

    // Observation vector: {illegal, mem_err, busy, PCWrite, PCSource, IorD, MemRd, MemWr,
    //                      IRWrite, ALUSrcA, ALUSrcB[1:0], ALUOp[1:0], RegDst, RegWrite, MemtoReg}
    localparam logic [16:0] M_BUSY = 17'h04000;
    localparam logic [16:0] M_PCW  = 17'h02000;
    localparam logic [16:0] M_PCS  = 17'h01000;
    localparam logic [16:0] M_IORD = 17'h00800;
    localparam logic [16:0] M_MR   = 17'h00400;
    localparam logic [16:0] M_MW   = 17'h00200;
    localparam logic [16:0] M_IRW  = 17'h00100;
    localparam logic [16:0] M_ASA  = 17'h00080;
    localparam logic [16:0] M_RDST = 17'h00004;
    localparam logic [16:0] M_RW   = 17'h00002;
    localparam logic [16:0] M_M2R  = 17'h00001;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mc_if #(.CNT_W(CNT_W)) bus ();

    multicycle_control #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int n_instr  = 0;
    logic [CNT_W-1:0] exp_ret;
    bit exp_ill;
    bit exp_err;
    bit ei;

    logic [16:0] eq[$];
    bit          aq[$];
    bit          zq[$];
    bit          sq[$];
    logic [5:0]  oq[$];

    function automatic logic [16:0] observed();
        return {bus.illegal_o, bus.mem_err_o, bus.busy_o, bus.PCWrite_o, bus.PCSource_o,
                bus.IorD_o, bus.Memory_read_o, bus.Memory_write_o, bus.IRWrite_o,
                bus.ALUSrcA_o, bus.ALUSrcB_o, bus.ALUOp_o, bus.RegDst_o, bus.RegWrite_o,
                bus.MemtoReg_o};
    endfunction

    function automatic logic [16:0] sb(input logic [1:0] x);
        return {10'b0, x, 5'b0};
    endfunction

    function automatic logic [16:0] ao(input logic [1:0] x);
        return {12'b0, x, 3'b0};
    endfunction

    function automatic bit legal(input logic [5:0] op);
        return op inside {T_R, T_ADDI, T_ORI, T_LW, T_SW, T_BEQ};
    endfunction

    function automatic bit rb();
        return ($urandom % 2) != 0;
    endfunction

    function automatic logic [5:0] rop();
        return 6'($urandom);
    endfunction

    task automatic check(input string tag, input logic [16:0] got, input logic [16:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic check_ret(input string tag);
        checks++;
        assert (bus.retired_o === exp_ret) else begin
            failures++;
            $error("FAIL %s_retired observed=%0d expected=%0d", tag, bus.retired_o, exp_ret);
        end
    endtask

    task automatic push(input logic [16:0] v, input bit ack, input logic [5:0] op, input bit z);
        eq.push_back(v);
        aq.push_back(ack);
        oq.push_back(op);
        zq.push_back(z);
        sq.push_back(rb());
    endtask

    // Builds the cycle-by-cycle expectation for one instruction, plays it, then updates the model.
    // kind: 0 = retires, 1 = illegal opcode, 2 = memory timeout.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input bit z,
                             input bit stop, input int cut, output bit ended_idle);
        int kind;
        int dec_idx;
        int lim;
        logic [16:0] fwv;
        logic [16:0] mv;
        logic [16:0] wbv;
        logic [16:0] v;
        eq.delete(); aq.delete(); zq.delete(); sq.delete(); oq.delete();
        kind    = 0;
        dec_idx = 0;
        fwv = M_BUSY | M_MR | sb(2'b01) | ao(2'b01);
        wbv = M_BUSY | M_RW | ((op == T_R) ? M_RDST : 17'h0) | ((op == T_LW) ? M_M2R : 17'h0);
        if (fw >= MEM_TIMEOUT) begin
            for (int k = 0; k < MEM_TIMEOUT; k++) push(fwv, 1'b0, rop(), rb());
            kind = 2;
        end else begin
            for (int k = 0; k < fw; k++) push(fwv, 1'b0, rop(), rb());
            push(fwv | M_PCW | M_IRW, 1'b1, rop(), rb());
            dec_idx = eq.size();
            push(M_BUSY | sb(2'b11) | ao(2'b01), rb(), op, rb());
            if (!legal(op)) begin
                kind = 1;
            end else if (op == T_R || op == T_ADDI || op == T_ORI) begin
                v = M_BUSY | M_ASA;
                if (op == T_R)         v = v | sb(2'b00) | ao(2'b00);
                else if (op == T_ADDI) v = v | sb(2'b10) | ao(2'b01);
                else                   v = v | sb(2'b10) | ao(2'b10);
                push(v, rb(), rop(), rb());
                push(wbv, rb(), rop(), rb());
            end else if (op == T_LW || op == T_SW) begin
                push(M_BUSY | M_ASA | sb(2'b10) | ao(2'b01), rb(), rop(), rb());
                mv = M_BUSY | M_IORD | ((op == T_LW) ? M_MR : M_MW);
                if (mw >= MEM_TIMEOUT) begin
                    for (int k = 0; k < MEM_TIMEOUT; k++) push(mv, 1'b0, rop(), rb());
                    kind = 2;
                end else begin
                    for (int k = 0; k < mw; k++) push(mv, 1'b0, rop(), rb());
                    push(mv, 1'b1, rop(), rb());
                    if (op == T_LW) push(wbv, rb(), rop(), rb());
                end
            end else begin
                push(M_BUSY | M_ASA | sb(2'b00) | ao(2'b11) | M_PCS | (z ? M_PCW : 17'h0),
                     rb(), rop(), z);
            end
        end
        if (kind == 0) begin
            if (stop) begin
                for (int k = dec_idx + 1; k < eq.size(); k++) sq[k] = 1'b1;
            end else begin
                sq[eq.size() - 1] = 1'b0;
            end
        end
        ended_idle = stop || (kind != 0);
        lim = (cut > 0) ? cut : eq.size();
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            bus.mem_ack_i = aq[i];
            bus.Op_i      = oq[i];
            bus.Zero_i    = zq[i];
            bus.stop_i    = sq[i];
            bus.start_i   = rb();
            #1;
            check($sformatf("i%0d_op%b_c%0d", n_instr, op, i), observed(), eq[i]);
            check_ret($sformatf("i%0d_c%0d", n_instr, i));
        end
        if (cut == 0) begin
            if (kind == 0) exp_ret = exp_ret + 1;
            if (kind == 1) exp_ill = 1'b1;
            if (kind == 2) exp_err = 1'b1;
        end
        n_instr++;
    endtask

    task automatic idle_start(input int n);
        for (int k = 0; k <= n; k++) begin
            @(negedge clk);
            bus.start_i   = (k == n);
            bus.mem_ack_i = rb();
            bus.stop_i    = rb();
            bus.Op_i      = rop();
            bus.Zero_i    = rb();
            #1;
            check($sformatf("idle_i%0d_k%0d", n_instr, k), observed(), {exp_ill, exp_err, 15'b0});
            check_ret($sformatf("idle_i%0d_k%0d", n_instr, k));
        end
        exp_ill = 1'b0;
        exp_err = 1'b0;
    endtask

    task automatic step(input logic [5:0] op, input int fw, input int mw, input bit z, input bit stop);
        bit e;
        run_instr(op, fw, mw, z, stop, 0, e);
        if (e) idle_start(1 + int'($urandom % 3));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] op;
        int r;
        rst_n         = 1'b0;
        bus.start_i   = 1'b1;
        bus.stop_i    = 1'b0;
        bus.mem_ack_i = 1'b1;
        bus.Op_i      = T_LW;
        bus.Zero_i    = 1'b1;
        exp_ret       = '0;
        exp_ill       = 1'b0;
        exp_err       = 1'b0;

        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            check("reset_hold", observed(), 17'h0);
            check_ret("reset_hold");
        end
        @(negedge clk);
        rst_n       = 1'b1;
        bus.start_i = 1'b0;
        idle_start(2);

        step(T_R,    0, 0, 1'b0, 1'b0);
        step(T_LW,   2, 3, 1'b0, 1'b0);
        step(T_BEQ,  0, 0, 1'b1, 1'b0);
        step(T_BEQ,  1, 0, 1'b0, 1'b0);
        step(T_SW,   0, 0, 1'b0, 1'b0);
        step(T_ADDI, 0, 0, 1'b0, 1'b0);
        step(T_ORI,  3, 0, 1'b1, 1'b0);
        step(T_J,    0, 0, 1'b0, 1'b0);
        step(T_R,    1, 0, 1'b0, 1'b1);
        step(T_R,   15, 0, 1'b0, 1'b0);
        step(T_LW,  14, 14, 1'b0, 1'b0);
        step(T_SW,   0, 15, 1'b0, 1'b0);
        step(T_LW,   0, 15, 1'b0, 1'b1);
        step(T_SW,   0, 14, 1'b0, 1'b1);

        for (int t = 0; t < 40; t++) begin
            r = int'($urandom % 10);
            case (r)
                0: op = T_R;
                1: op = T_ADDI;
                2: op = T_ORI;
                3, 4: op = T_LW;
                5, 8: op = T_SW;
                6, 7: op = T_BEQ;
                default: begin
                    op = rop();
                    for (int g = 0; g < 8 && legal(op); g++) op = rop();
                    if (legal(op)) op = T_J;
                end
            endcase
            step(op, int'($urandom % 5), int'($urandom % 5), rb(), ($urandom % 5) == 0);
        end

        // Reset while a sw is holding its write request.
        run_instr(T_SW, 0, 5, 1'b0, 1'b0, 6, ei);
        #2;
        rst_n   = 1'b0;
        exp_ret = '0;
        exp_ill = 1'b0;
        exp_err = 1'b0;
        #1;
        check("reset_mid_sw", observed(), 17'h0);
        check_ret("reset_mid_sw");
        @(negedge clk);
        #1;
        check("reset_mid_sw_hold", observed(), 17'h0);
        rst_n = 1'b1;
        idle_start(1);
        step(T_R, 0, 0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer for the single-ported MIPS datapath. Owns one instruction's progress through FETCH, DECODE, EXECUTE, MEM and WB.
- Drives per-state datapath controls and handshakes with a variable-latency memory.
- Supports R-type (000000), addi (001000), ori (001101), lw (100011), sw (101011) and beq (000100).
- Sits between the IR/ALU-zero feedback and the PC/IR/register-file/memory enables.

Parameters:
- MEM_TIMEOUT, 15: maximum cycles a memory request waits for mem_ack_i before it is aborted.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-low reset.
- start_i  in  1  level; leaves IDLE.
- stop_i  in  1  level; sampled only at instruction boundary.
- Op_i  in  6  opcode from IR; valid from DECODE onward.
- Zero_i  in  1  ALU zero flag.
- mem_ack_i  in  1  memory completion, single-cycle pulse.
- PCWrite_o  out  1  unconditional PC write.
- PCSource_o  out  1  0 = ALU result (PC+4); 1 = ALUOut (branch target).
- IorD_o  out  1  0 = PC addresses memory; 1 = ALUOut addresses memory.
- Memory_read_o  out  1  memory read request.
- Memory_write_o  out  1  memory write request.
- IRWrite_o  out  1  load IR.
- ALUSrcA_o  out  1  0 = PC; 1 = rs.
- ALUSrcB_o  out  2  00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = imm<<2.
- ALUOp_o  out  2  00 = funct, 01 = ADD, 10 = OR, 11 = SUB.
- RegDst_o  out  1  1 = rd, 0 = rt.
- RegWrite_o  out  1  register-file write.
- MemtoReg_o  out  1  1 = MDR to register file.
- busy_o  out  1  state != IDLE.
- illegal_o  out  1  sticky: unsupported opcode.
- mem_err_o  out  1  sticky: memory timeout.
- retired_o  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=IDLE; op_r=0; timeout counter=0; retired_o=0; illegal_o=0; mem_err_o=0.
  - Every control output is 0 for the whole time reset is asserted, including reset mid-instruction. No partial writes occur after reset deasserts.
- Outputs are Moore: a combinational decode of the state register and the latched op_r. Unlisted outputs are 0 in every state.
- IDLE:
  - start_i=1 → FETCH.
  - Entering FETCH clears illegal_o and mem_err_o.
- FETCH:
  - Outputs: Memory_read_o=1, IorD_o=0, ALUSrcA_o=0, ALUSrcB_o=01, ALUOp_o=01.
  - IRWrite_o=1 and PCWrite_o=1 only in the cycle where mem_ack_i=1; that cycle → DECODE.
- DECODE:
  - op_r<=Op_i. Outputs: ALUSrcA_o=0, ALUSrcB_o=11, ALUOp_o=01 (branch target into ALUOut).
  - Next state: R/addi/ori → EXEC; lw/sw → ADDR; beq → BRANCH.
  - Any other opcode: illegal_o<=1 → IDLE, no retire.
- EXEC:
  - ALUSrcA_o=1.
  - R-type: ALUSrcB_o=00, ALUOp_o=00. addi: ALUSrcB_o=10, ALUOp_o=01. ori: ALUSrcB_o=10, ALUOp_o=10.
  - → WB.
- ADDR: ALUSrcA_o=1, ALUSrcB_o=10, ALUOp_o=01 → MEM.
- MEM:
  - IorD_o=1. Memory_read_o=1 for lw; Memory_write_o=1 for sw.
  - Request is held steady until mem_ack_i.
  - On ack: lw → WB; sw retires → boundary.
- WB:
  - RegWrite_o=1. RegDst_o=1 iff R-type. MemtoReg_o=1 iff lw.
  - Retires → boundary.
- BRANCH:
  - ALUSrcA_o=1, ALUSrcB_o=00, ALUOp_o=11, PCSource_o=1.
  - PCWrite_o = Zero_i (combinational, this cycle only).
  - Retires → boundary.
- Boundary:
  - stop_i=1 → IDLE; else → FETCH.
  - stop_i is ignored in every other state.
- Retire:
  - retired_o increments by 1 on the last cycle of an instruction; wraps modulo 2^CNT_W.
  - A timeout or illegal opcode does not retire.
- Timeout:
  - Counter clears on entry to FETCH or MEM and increments each waiting cycle.
  - If it reaches MEM_TIMEOUT with no ack: mem_err_o<=1, drop request → IDLE.
  - An ack arriving in the same cycle as the limit wins: normal progress, no error.
- Ack outside FETCH/MEM is ignored.
- Latency with zero-wait memory (ack in the first request cycle):
  - R/addi/ori/lw-less-MEM = 4 cycles; lw = 5; sw = 4; beq = 3.
  - Each extra wait cycle adds 1.

Decomposition:
- Package mc_pkg holds:
  - state enum (IDLE, FETCH, DECODE, EXEC, ADDR, MEM, WB, BRANCH), 3-bit.
  - opcode constants: OP_R, OP_ADDI, OP_ORI, OP_LW, OP_SW, OP_BEQ.
  - ALUOp codes and ALUSrcB select codes.
- Sub-module mc_mem_timer: timeout counter with clear/enable/expired. The FSM and output decode stay in multicycle_control.

Test Plan:
- Reset mid-MEM of sw with Memory_write_o=1 → all outputs 0 immediately; after release, state IDLE and retired_o=0.
- start_i=1; R-type add with ack on the first fetch cycle → IRWrite_o/PCWrite_o pulse in cycle 1; cycle 4 shows RegWrite_o=1, RegDst_o=1; retired_o=1.
- lw with fetch ack after 2 waits and MEM ack after 3 waits → 10 cycles total; MemtoReg_o=1 and RegWrite_o=1 in WB; Memory_read_o is steady throughout the waits.
- beq with Zero_i=1 → PCWrite_o=1, PCSource_o=1 in BRANCH. Repeat with Zero_i=0 → PCWrite_o=0. Both retire.
- Op_i=000010 (j) → illegal_o=1, IDLE, retired_o unchanged. Next start_i → illegal_o cleared.
- MEM_TIMEOUT=15, no ack → mem_err_o=1 after 15 wait cycles, back in IDLE. Ack exactly at cycle 15 → no error.
- stop_i asserted during EXEC → current instruction completes (WB), then IDLE with busy_o=0.
